arith_unit_pipe: RTL and testbench
==================================

ARITH_UNIT_PIPE -- requirements
Module: arith_unit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  operation request present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 The block SHALL have port a  input  WIDTH  operand A.
REQ-007 The block SHALL have port b  input  WIDTH  operand B.
REQ-008 The block SHALL have port cin  input  1  carry-in.
REQ-009 The block SHALL have port sel  input  2  operation select.
REQ-010 The block SHALL have port acc_en  input  1  use internal accumulator in place of A.
REQ-011 The block SHALL have port clr_flags  input  1  clear sticky flags.
REQ-012 The block SHALL have port out_valid  output  1  result registers hold an undelivered result.
REQ-013 The block SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-014 The block SHALL have port out  output  WIDTH  result.
REQ-015 The block SHALL have port carry  output  1  carry out of MSB for the result.
REQ-016 The block SHALL have ports Z, N, V  output  1 each  zero, negative (out MSB), signed overflow.
REQ-017 The block SHALL have ports sticky_c, sticky_v  output  1 each  carry/overflow seen since last clear.

Function
REQ-018 Operand X SHALL be the accumulator register when acc_en=1 at acceptance, else a.
REQ-019 sel=00 SHALL compute X + b + cin; sel=01 X + ~b + cin (cin=1 gives X-b); sel=10 X + cin; sel=11 X + all-ones + cin (cin=0 gives X-1).
REQ-020 Sums SHALL be WIDTH+1 bits; out = low WIDTH bits, carry = bit WIDTH; no truncation warnings or sign extension of operands.
REQ-021 V SHALL be 1 when the two effective addends have equal MSB and out MSB differs from it; Z SHALL be 1 when out is all zeros.
REQ-022 A transfer in SHALL occur when in_valid=1 and in_ready=1; in_ready SHALL equal (!out_valid || out_ready).
REQ-023 Latency SHALL be exactly one cycle: result, flags, out_valid=1 registered on the edge of acceptance.
REQ-024 A transfer out SHALL occur when out_valid=1 and out_ready=1; out_valid SHALL drop next edge unless a new transfer in occurs the same cycle (full throughput, one result per cycle).
REQ-025 While out_valid=1 and out_ready=0, out and all flags SHALL remain stable and no input SHALL be accepted.
REQ-026 The accumulator SHALL load out on every transfer in, regardless of acc_en, so back-to-back acc_en operations chain without bubbles.
REQ-027 sticky_c/sticky_v SHALL set on a transfer in whose carry/V is 1; clr_flags SHALL clear them; set SHALL win when both occur in one cycle.
REQ-028 in_valid=1 with in_ready=0 SHALL not alter any state; inputs need not be held by the block.

Reset
REQ-029 With rst=1 at a rising edge: out_valid, out, carry, Z, N, V, sticky_c, sticky_v, accumulator SHALL all become 0.
REQ-030 rst SHALL override any simultaneous transfer in/out; a pending result SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Verification (WIDTH=8)
REQ-032 a=FF b=01 cin=0 sel=00, out_ready=1 -> next cycle out=00 carry=1 Z=1 N=0 V=0 out_valid=1.
REQ-033 a=80 b=01 cin=1 sel=01 -> out=7F carry=1 V=1 N=0 Z=0; sticky_v=1 until clr_flags.
REQ-034 out_ready=0 after a result, in_valid held with new operands -> in_ready=0, out unchanged for 5 cycles; out_ready=1 -> held request accepted, new result next cycle.
REQ-035 From reset, acc_en=1 b=03 sel=00 cin=0 on 3 consecutive cycles, out_ready=1 -> out 03, 06, 09 on consecutive cycles.
REQ-036 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out=00, all flags 0; then acc_en=1 sel=10 cin=1 -> out=01.
REQ-037 clr_flags=1 in same cycle as accepted op with carry=1 -> sticky_c=1 next cycle; clr_flags alone next -> sticky_c=0.

Source files
------------

// File: rtl/arith_unit_pipe.sv
// arith_unit_pipe: a one-stage pipelined adder/subtractor with an accumulator.
// It uses a valid/ready handshake on both sides and keeps sticky carry and
// overflow flags. A result is registered on the same edge that accepts its
// request. A new request can be accepted while the previous result is being
// delivered, which gives one result per cycle.
module arith_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       sel,
  input  logic             acc_en,
  input  logic             clr_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             sticky_c,
  output logic             sticky_v
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_reg;
  logic             carry_reg;
  logic             z_reg;
  logic             n_reg;
  logic             v_reg;
  logic             sticky_c_reg;
  logic             sticky_v_reg;
  logic [WIDTH-1:0] acc_reg;

  logic             xfer_in;
  logic [WIDTH-1:0] x_op;
  logic [WIDTH-1:0] y_op;
  logic [WIDTH:0]   sum_next;
  logic             v_next;
  logic             sticky_c_next;
  logic             sticky_v_next;

  // The output stage can take a new result when it is empty or is being drained now.
  assign in_ready = !out_valid_reg || out_ready;
  assign xfer_in  = in_valid && in_ready;

  assign x_op = acc_en ? acc_reg : a;

  // Build the second addend bit by bit:
  //   sel=00 -> b
  //   sel=01 -> ~b
  //   sel=10 -> all zeros
  //   sel=11 -> all ones
  // sel[1] selects a constant, and sel[0] gives its value or the inversion of b.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_yop
      assign y_op[gi] = sel[1] ? sel[0] : (b[gi] ^ sel[0]);
    end
  endgenerate

  // Form the full-width sum. Operands are zero-extended, so bit WIDTH is the true carry out.
  always_comb begin
    sum_next      = {1'b0, x_op} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
    v_next        = (x_op[WIDTH-1] == y_op[WIDTH-1]) &&
                    (sum_next[WIDTH-1] != x_op[WIDTH-1]);
    sticky_c_next = (sticky_c_reg && !clr_flags) || (xfer_in && sum_next[WIDTH]);
    sticky_v_next = (sticky_v_reg && !clr_flags) || (xfer_in && v_next);
  end

  // Result, flag, accumulator and handshake state.
  // The result registers stay unchanged until the next accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      carry_reg     <= 1'b0;
      z_reg         <= 1'b0;
      n_reg         <= 1'b0;
      v_reg         <= 1'b0;
      sticky_c_reg  <= 1'b0;
      sticky_v_reg  <= 1'b0;
      acc_reg       <= '0;
    end else begin
      sticky_c_reg <= sticky_c_next;
      sticky_v_reg <= sticky_v_next;
      if (xfer_in) begin
        out_valid_reg <= 1'b1;
        out_reg       <= sum_next[WIDTH-1:0];
        carry_reg     <= sum_next[WIDTH];
        z_reg         <= (sum_next[WIDTH-1:0] == '0);
        n_reg         <= sum_next[WIDTH-1];
        v_reg         <= v_next;
        acc_reg       <= sum_next[WIDTH-1:0];
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign carry     = carry_reg;
  assign Z         = z_reg;
  assign N         = n_reg;
  assign V         = v_reg;
  assign sticky_c  = sticky_c_reg;
  assign sticky_v  = sticky_v_reg;

endmodule

// File: tb/tb_arith_unit_pipe.sv
// Testbench for arith_unit_pipe (WIDTH=8).
// The model runs on the rising edge. It decides acceptance from the bench's own
// handshake model and pushes expected results into a queue. A monitor on the
// falling edge pops results as they are delivered and compares them. The
// monitor also checks the handshake and the sticky flags every cycle.
module tb_arith_unit_pipe;

  localparam int W    = 8;
  localparam int MASK = 255;

  typedef struct {
    int res;
    int c;
    int z;
    int n;
    int v;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [1:0]   sel;
  logic         acc_en;
  logic         clr_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
  logic         Z;
  logic         N;
  logic         V;
  logic         sticky_c;
  logic         sticky_v;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  exp_t q[$];
  int   m_acc    = 0;
  int   m_valid  = 0;
  int   m_sc     = 0;
  int   m_sv     = 0;
  int   m_rst    = 0;
  int   armed    = 0;
  int   n_issued = 0;

  arith_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sel(sel), .acc_en(acc_en), .clr_flags(clr_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .carry(carry),
    .Z(Z), .N(N), .V(V), .sticky_c(sticky_c), .sticky_v(sticky_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arithmetic on plain integers, evaluated on every rising edge.
  always @(posedge clk) begin
    int   xv, yv, s, sx, sy, ss, rdy, accept;
    exp_t e;
    if (rst) begin
      q.delete();
      m_acc   = 0;
      m_valid = 0;
      m_sc    = 0;
      m_sv    = 0;
      m_rst   = 1;
      armed   = 1;
    end else begin
      m_rst  = 0;
      rdy    = (!m_valid || out_ready) ? 1 : 0;
      accept = (in_valid && rdy) ? 1 : 0;
      e = '{res: 0, c: 0, z: 0, n: 0, v: 0};
      if (accept != 0) begin
        xv = acc_en ? m_acc : int'(a);
        case (sel)
          2'b00:   yv = int'(b);
          2'b01:   yv = (~int'(b)) & MASK;
          2'b10:   yv = 0;
          default: yv = MASK;
        endcase
        s     = xv + yv + int'(cin);
        e.res = s & MASK;
        e.c   = (s >> W) & 1;
        e.z   = (e.res == 0) ? 1 : 0;
        e.n   = (e.res >> (W - 1)) & 1;
        sx    = (xv >= 128) ? xv - 256 : xv;
        sy    = (yv >= 128) ? yv - 256 : yv;
        ss    = sx + sy + int'(cin);
        e.v   = (ss > 127 || ss < -128) ? 1 : 0;
        q.push_back(e);
        m_acc = e.res;
        n_issued++;
      end
      m_sc = ((m_sc != 0 && !clr_flags) || (accept != 0 && e.c != 0)) ? 1 : 0;
      m_sv = ((m_sv != 0 && !clr_flags) || (accept != 0 && e.v != 0)) ? 1 : 0;
      if (accept != 0)    m_valid = 1;
      else if (out_ready) m_valid = 0;
    end
  end

  // Monitor: compare the registered outputs against the model on the falling edge.
  always @(negedge clk) begin
    if (armed != 0) begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("in_ready", 64'(in_ready), 64'((!m_valid || out_ready) ? 1 : 0));
      check("sticky_c", 64'(sticky_c), 64'(m_sc));
      check("sticky_v", 64'(sticky_v), 64'(m_sv));
      if (m_rst != 0) begin
        check("rst_out", 64'(out), 64'(0));
        check("rst_flags", 64'({carry, Z, N, V}), 64'(0));
      end
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got out=%0h expected none", out);
        end else begin
          check("out", 64'(out), 64'(q[0].res));
          check("carry", 64'(carry), 64'(q[0].c));
          check("Z", 64'(Z), 64'(q[0].z));
          check("N", 64'(N), 64'(q[0].n));
          check("V", 64'(V), 64'(q[0].v));
          if (out_ready) begin
            $display("xfer out=%02h c=%0d z=%0d n=%0d v=%0d", out, carry, Z, N, V);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // Drive one cycle of inputs and advance to just after the next rising edge.
  task automatic step(input logic iv, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [1:0] ts, input logic tacc,
                      input logic tclr, input logic tordy, input logic trst);
    in_valid  = iv;
    a         = ta;
    b         = tb;
    cin       = tc;
    sel       = ts;
    acc_en    = tacc;
    clr_flags = tclr;
    out_ready = tordy;
    rst       = trst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    in_valid = 0; a = 0; b = 0; cin = 0; sel = 0; acc_en = 0;
    clr_flags = 0; out_ready = 1; rst = 1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Chain three accumulator adds straight out of reset.
    // The expected outputs are 03, 06 and 09.
    for (int i = 0; i < 3; i++) step(1, 8'h55, 8'h03, 0, 2'b00, 1, 0, 1, 0);
    idle(1);

    // FF + 01 gives a result of zero with a carry out.
    step(1, 8'hFF, 8'h01, 0, 2'b00, 0, 0, 1, 0);
    idle(1);

    // 80 - 01 gives 7F with signed overflow.
    // sticky_v must hold until it is cleared.
    step(1, 8'h80, 8'h01, 1, 2'b01, 0, 0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);

    // Stall the output for 5 cycles while a new request is held.
    // Then release the output so the held request is taken.
    step(1, 8'h10, 8'h20, 0, 2'b00, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'h33, 8'h44, 0, 2'b00, 0, 0, 0, 0);
    step(1, 8'h33, 8'h44, 0, 2'b00, 0, 0, 1, 0);
    idle(2);

    // Assert a clear in the same cycle as a carry-producing op: set wins.
    // A clear on its own then drops sticky_c.
    step(1, 8'hFF, 8'h01, 0, 2'b00, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(1);

    // Reset while a result is stalled.
    // Afterwards, acc + 0 + cin gives 01.
    step(1, 8'hC0, 8'hC0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 8'h01, 8'h01, 0, 2'b00, 0, 0, 0, 0);
    step(1, 8'h01, 8'h01, 0, 2'b00, 0, 0, 0, 1);
    step(1, 8'hAA, 8'h00, 1, 2'b10, 1, 0, 1, 0);
    idle(2);

    // Random traffic with random backpressure, clears and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           1'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 99) == 0));
    end

    // Drain the pipeline, then confirm every issued result was delivered.
    idle(4);
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("issued %0d operations", n_issued);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
